// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for the five-stage MIPS pipeline: load-use stall, MEM-stage flush, data-memory freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegDstData,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             MEM_Branch,
  input  logic             MEM_Zero,
  input  logic             MEM_Jump,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             PC_Ld,
  output logic             IFID_Ld,
  output logic             IDEX_Ld,
  output logic             EXMEM_Ld,
  output logic             MEMWB_Ld,
  output logic             IFID_Clr,
  output logic             IDEX_Clr,
  output logic             EXMEM_Clr,
  output logic             MEMWB_Clr,
  output logic             PCSrc,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    S_RUN     = 1'b0,
    S_MEMWAIT = 1'b1
  } state_e;

  // Winning condition of the cycle, in priority order.
  typedef enum logic [2:0] {
    R_NONE    = 3'd0,
    R_RESET   = 3'd1,
    R_MEMWAIT = 3'd2,
    R_FLUSH   = 3'd3,
    R_LOADUSE = 3'd4
  } rule_e;

  state_e state_q;
  state_e state_d;
  rule_e  rule_s;
  logic   access_s;
  logic   taken_s;
  logic   loaduse_s;
  logic   memwait_s;

  assign access_s  = MEM_MemRead | MEM_MemWrite;
  assign taken_s   = (MEM_Branch & MEM_Zero) | MEM_Jump;
  assign memwait_s = access_s & ~MemReady;
  assign loaduse_s = EX_MemRead & (EX_RegDstData != 5'd0) &
                     ((EX_RegDstData == ID_Rs) | (ID_UsesRt & (EX_RegDstData == ID_Rt)));

  always_comb begin
    rule_s = R_NONE;
    if (Clr) begin
      rule_s = R_RESET;
    end else if (memwait_s) begin
      rule_s = R_MEMWAIT;
    end else if (taken_s) begin
      rule_s = R_FLUSH;
    end else if (loaduse_s) begin
      rule_s = R_LOADUSE;
    end else begin
      rule_s = R_NONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A wait that releases (or an access that disappears) always returns to S_RUN.
  always_comb begin
    state_d = S_RUN;
    case (state_q)
      S_RUN: begin
        if (rule_s == R_MEMWAIT) begin
          state_d = S_MEMWAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (rule_s == R_MEMWAIT) begin
          state_d = S_MEMWAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    PC_Ld     = 1'b1;
    IFID_Ld   = 1'b1;
    IDEX_Ld   = 1'b1;
    EXMEM_Ld  = 1'b1;
    MEMWB_Ld  = 1'b1;
    IFID_Clr  = 1'b0;
    IDEX_Clr  = 1'b0;
    EXMEM_Clr = 1'b0;
    MEMWB_Clr = 1'b0;
    PCSrc     = 1'b0;
    // The start pulse is issued only once, on the first cycle the access is seen.
    MemReq    = (state_q == S_RUN) & access_s & (rule_s != R_RESET);
    case (rule_s)
      R_RESET: begin
        PC_Ld     = 1'b0;
        IFID_Ld   = 1'b0;
        IDEX_Ld   = 1'b0;
        EXMEM_Ld  = 1'b0;
        MEMWB_Ld  = 1'b0;
        IFID_Clr  = 1'b1;
        IDEX_Clr  = 1'b1;
        EXMEM_Clr = 1'b1;
        MEMWB_Clr = 1'b1;
      end
      R_MEMWAIT: begin
        PC_Ld     = 1'b0;
        IFID_Ld   = 1'b0;
        IDEX_Ld   = 1'b0;
        EXMEM_Ld  = 1'b0;
        MEMWB_Ld  = 1'b0;
        MEMWB_Clr = 1'b1;
      end
      R_FLUSH: begin
        PCSrc     = 1'b1;
        IFID_Clr  = 1'b1;
        IDEX_Clr  = 1'b1;
        EXMEM_Clr = 1'b1;
      end
      R_LOADUSE: begin
        PC_Ld     = 1'b0;
        IFID_Ld   = 1'b0;
        IDEX_Clr  = 1'b1;
      end
      R_NONE: begin
        PCSrc     = 1'b0;
      end
      default: begin
        PCSrc     = 1'b0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating counters; a stall is either a memory freeze or a load-use bubble.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rule_s == R_RESET) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else if ((rule_s == R_MEMWAIT) || (rule_s == R_LOADUSE)) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else if (rule_s == R_FLUSH) begin
      if (flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = {CNT_W{1'b0}};
  assign FlushCount = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard and stall controller for the five-stage MIPS datapath. Drives the Ld and Clr inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are the values those registers present. Resolves three conditions: a load-use stall, a flush on a branch or jump taken in MEM, and a freeze while the data memory finishes a variable-latency access over a request/ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Clr  in  1  reset, synchronous and active-high.
- ID_Rs, ID_Rt  in  5 each  source register fields of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads Rt.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_RegDstData  in  5  destination register of the instruction in EX.
- MEM_MemRead, MEM_MemWrite  in  1 each  the instruction in MEM accesses data memory.
- MEM_Branch, MEM_Zero, MEM_Jump  in  1 each  branch and jump resolution at MEM.
- MemReady  in  1  data memory has completed the access.
- MemReq  out  1  one-cycle access start pulse to data memory.
- PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld  out  1 each  register load enables.
- IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr  out  1 each  synchronous bubble insert.
- PCSrc  out  1  selects the branch or jump target for the PC.
- StallCount, FlushCount  out  CNT_W each  performance counters.

## Operation
- FSM states: S_RUN (encoding 0) and S_MEMWAIT (encoding 1).
- Outputs are Mealy: they depend on the state and the current inputs.
- Define access = MEM_MemRead | MEM_MemWrite.
- Define taken = (MEM_Branch & MEM_Zero) | MEM_Jump.
- Define loaduse = EX_MemRead & (EX_RegDstData != 0) & ((EX_RegDstData == ID_Rs) | (ID_UsesRt & (EX_RegDstData == ID_Rt))).
- Default outputs: every Ld = 1, every Clr = 0, PCSrc = 0, MemReq = 0.
- Conditions are evaluated in priority order; the first one that matches wins.
  1. Clr high: all Ld = 0, all *_Clr = 1, MemReq = 0, PCSrc = 0. Next state is S_RUN; counters clear.
  2. Memory wait: access & !MemReady. Applies to S_RUN on the first cycle of the access, and to S_MEMWAIT while MemReady is low.
     - All Ld = 0 and MEMWB_Clr = 1; a bubble goes into WB.
     - Next state is S_MEMWAIT; StallCount increments.
  3. Branch or jump taken:
     - PCSrc = 1, PC_Ld = 1.
     - IFID_Clr = IDEX_Clr = EXMEM_Clr = 1, which flushes the three younger instructions.
     - FlushCount increments.
  4. Load-use:
     - PC_Ld = 0, IFID_Ld = 0, IDEX_Clr = 1; EX/MEM and MEM/WB advance.
     - StallCount increments.
- MemReq = 1 only in S_RUN with access high: exactly one pulse per access.
- MemReq and MemReady may both be high in the same cycle (zero-wait access). In that case nothing stalls and the state stays S_RUN.
- In S_MEMWAIT with MemReady = 1:
  - The pipeline advances this cycle and the next state is S_RUN.
  - Rules 3 and 4 are evaluated in this same cycle.
  - MemReq stays 0.
- A branch and an access are never both in MEM in legal code. If both occur, rule 2 wins; the branch is acted on in the cycle MemReady releases.
- When the load sits in EX and a taken branch sits in MEM, rule 3 wins and the load-use bubble is discarded with the flush.
- Counters saturate at all-ones and do not wrap.

## Timing
- Latency: the control outputs take effect on the same posedge as the inputs that cause them. The registers sample Ld and Clr at the next Clk edge.
- A load-use stall costs exactly 1 cycle.
- A taken branch or jump costs 3 flushed slots.
- A memory access with ready arriving N cycles after MemReq costs N stall cycles; N = 0 costs none.
- Reset mid-wait: S_MEMWAIT drops to S_RUN on the posedge with Clr high, and the pending access is abandoned. Outputs follow rule 1 throughout the cycle in which Clr is high.
- Reset values: state S_RUN, StallCount = 0, FlushCount = 0.

## Configuration
- HAZARD_PERF_CNT_EN:
  - Defined: StallCount and FlushCount are implemented as described above.
  - Undefined: both outputs are tied to 0 and no counter flops are synthesized. Control behaviour is identical either way.

## Test plan
- Load-use: EX_MemRead = 1, EX_RegDstData = 8, ID_Rs = 8 -> one cycle with PC_Ld = 0, IFID_Ld = 0, IDEX_Clr = 1; StallCount goes 0 to 1.
- No false stall:
  - EX_RegDstData = 0 and ID_Rs = 0 -> no stall.
  - ID_Rt match with ID_UsesRt = 0 -> no stall.
- Taken branch: MEM_Branch = 1, MEM_Zero = 1 -> PCSrc = 1 and IFID_Clr = IDEX_Clr = EXMEM_Clr = 1 for 1 cycle; FlushCount = 1.
  - Repeat with MEM_Zero = 0 -> no flush.
- Memory wait: MEM_MemRead = 1, MemReady low for 3 cycles then high.
  - MemReq pulses once.
  - 3 frozen cycles with MEMWB_Clr = 1, then the pipeline advances.
  - StallCount = 3; state returns to S_RUN.
- Zero-wait access: MEM_MemWrite = 1 with MemReady = 1 in the same cycle -> MemReq = 1, all Ld = 1, state stays S_RUN.
- Reset in S_MEMWAIT: assert Clr for 1 cycle on the 2nd wait cycle.
  - During that cycle, all Clr outputs = 1 and all Ld = 0.
  - Afterwards the state is S_RUN and both counters are 0.
  - With HAZARD_PERF_CNT_EN undefined, both counters read 0 throughout.
